set_unit: RTL and testbench

SET_UNIT -- requirements
Module: set_unit

---
 rtl/set_unit.sv | 155 +++++++++++++++
 tb/tb_set_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_unit.sv
// set_unit: two-stage pipelined set-on-compare unit.
// S1 registers the opcode and operands; S2 registers the 1-bit set result and
// the {lt, gt, eq} flags. A running 16-bit count tracks retired beats whose
// result was 1.
//
// Handshake: a beat moves across an interface only on a rising edge where
// valid && ready are both high. in_ready never looks at in_valid. While
// out_valid is high and out_ready is low, result/flags/out_valid hold steady.

module set_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [2:0]   flags,
    output logic [15:0]  count
);

    // Opcode encodings.
    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_SNE  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SGE  = 3'b011;
    localparam logic [2:0] OP_SLTU = 3'b100;
    localparam logic [2:0] OP_SGEU = 3'b101;
    localparam logic [2:0] OP_SGT  = 3'b110;
    localparam logic [2:0] OP_SLE  = 3'b111;

    // Goes high on the first edge after reset release; holds in_ready low
    // while reset is asserted and until the block has seen a clock.
    logic         r_live;

    logic         r_s1_valid;
    logic [2:0]   r_s1_op;
    logic [N-1:0] r_s1_a;
    logic [N-1:0] r_s1_b;

    logic         r_s2_valid;
    logic         r_s2_res;
    logic [2:0]   r_s2_flags;

    logic [15:0]  r_count;

    logic         w_s1_adv;
    logic         w_in_fire;
    logic         w_retire;
    logic         w_signed;
    logic         w_eq;
    logic         w_lt;
    logic         w_gt;
    logic         w_res;

    // Pipeline control: S1 advances into S2 when S2 is empty or draining.
    always_comb begin
        w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
        in_ready  = r_live && !flush && (!r_s1_valid || w_s1_adv);
        w_in_fire = in_valid && in_ready;
        // A flush cycle retires nothing, so count cannot move under flush.
        w_retire  = r_s2_valid && out_ready && !flush;
    end

    // Compare on the S1-registered operands. Signed ops are SLT, SGE, SGT,
    // SLE (op[1]=1); SEQ/SNE report unsigned ordering in lt/gt.
    always_comb begin
        w_signed = r_s1_op[1];
        w_eq     = (r_s1_a == r_s1_b);
        if (w_signed) begin
            w_lt = ($signed(r_s1_a) < $signed(r_s1_b));
        end else begin
            w_lt = (r_s1_a < r_s1_b);
        end
        w_gt  = !w_lt && !w_eq;
        w_res = 1'b0;
        case (r_s1_op)
            OP_SEQ:  w_res = w_eq;
            OP_SNE:  w_res = !w_eq;
            OP_SLT:  w_res = w_lt;
            OP_SGE:  w_res = !w_lt;
            OP_SLTU: w_res = w_lt;
            OP_SGEU: w_res = !w_lt;
            OP_SGT:  w_res = w_gt;
            OP_SLE:  w_res = !w_gt;
            default: w_res = 1'b0;
        endcase
    end

    // Liveness flag for in_ready after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Stage S1: capture op/a/b on input transfer; empties when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 3'b000;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= op;
            r_s1_a     <= a;
            r_s1_b     <= b;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage S2: load the compare outcome from S1, or empty on retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= 1'b0;
            r_s2_flags <= 3'b000;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_res   <= w_res;
            r_s2_flags <= {w_lt, w_gt, w_eq};
        end else if (w_retire) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Count of retired true results; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'd0;
        end else if (w_retire && r_s2_res) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = {{(N-1){1'b0}}, r_s2_res};
    assign flags     = r_s2_flags;
    assign count     = r_count;

endmodule

// File: tb/tb_set_unit.sv
// Testbench for set_unit: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of in-flight beats.

module tb_set_unit;

    localparam int N = 32;
    localparam int W = N + 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] result;
    logic [2:0]   flags;
    logic [15:0]  count;

    set_unit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .count     (count)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: one entry per accepted, not yet retired beat,
    // packed as {result[N-1:0], lt, gt, eq}.
    logic [W-1:0] exp_q[$];
    logic [15:0]  m_count = 16'd0;
    bit           m_live = 1'b0;
    bit           g_in_fire = 1'b0;
    int           n_retired = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected beat from the opcode table and two's complement arithmetic.
    function automatic logic [W-1:0] ref_beat(input logic [2:0] o, input logic [N-1:0] x,
                                              input logic [N-1:0] y);
        bit sgn, lt, gt, eq, r;
        logic [N-1:0] rv;
        sgn = (o inside {3'b010, 3'b011, 3'b110, 3'b111});
        eq  = (x == y);
        lt  = sgn ? ($signed(x) < $signed(y)) : (x < y);
        gt  = !eq && !lt;
        case (o)
            3'b000: r = eq;
            3'b001: r = !eq;
            3'b010: r = lt;
            3'b011: r = !lt;
            3'b100: r = lt;
            3'b101: r = !lt;
            3'b110: r = gt;
            default: r = !gt;
        endcase
        rv = '0;
        rv[0] = r;
        return {rv, lt, gt, eq};
    endfunction

    // One clock cycle. Called at a falling edge with inputs already set.
    task automatic cycle();
        logic rdy_exp, in_fire, out_fire;
        logic [W-1:0] nb, tmp;
        #1;
        rdy_exp = m_live && !flush && ((exp_q.size() < 2) || out_ready);
        check("in_ready", in_ready, rdy_exp);
        if (exp_q.size() == 0) check("ovalid_idle", out_valid, 1'b0);
        if (out_valid && exp_q.size() > 0) check("beat", {result, flags}, exp_q[0]);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready && !flush && (exp_q.size() > 0);
        nb = ref_beat(op, a, b);
        @(posedge clk);
        m_live = 1'b1;
        g_in_fire = in_fire;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_fire) begin
                tmp = exp_q.pop_front();
                if (tmp[3]) m_count++;
                n_retired++;
            end
            if (in_fire) exp_q.push_back(nb);
        end
        #1;
        check("count", count, m_count);
        @(negedge clk);
    endtask

    // Apply reset with the pipeline in whatever state, then release it.
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", in_ready, 1'b0);
        check("rst_ovalid", out_valid, 1'b0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 3'b000);
        check("rst_count", count, 16'd0);
        exp_q.delete();
        m_count = 16'd0;
        m_live = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_pre_edge", in_ready, 1'b0);
        @(negedge clk);
        #1;
        check("rdy_post_edge", in_ready, 1'b1);
        m_live = 1'b1;
        @(negedge clk);
    endtask

    // Send one beat into an empty pipeline and check the fixed 2-cycle latency.
    task automatic send_expect(input string tag, input logic [2:0] o, input logic [N-1:0] x,
                               input logic [N-1:0] y, input logic r, input logic [2:0] f);
        logic [N-1:0] rv;
        rv = '0;
        rv[0] = r;
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, out_valid, 1'b0);
        cycle();
        #1;
        check({tag, "_lat2"}, out_valid, 1'b1);
        check({tag, "_res"}, result, rv);
        check({tag, "_flags"}, flags, f);
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [N-1:0] bnd [5];

    initial begin
        int acc, tries, r0, c0;
        logic [N-1:0] bp_a [4];
        bnd[0] = 32'h0000_0000; bnd[1] = 32'h0000_0001; bnd[2] = 32'h8000_0000;
        bnd[3] = 32'h7FFF_FFFF; bnd[4] = 32'hFFFF_FFFF;
        @(negedge clk);
        do_reset();

        // Streaming SEQ, latency, first count.
        send_expect("seq", 3'b000, 32'h1234_5678, 32'h1234_5678, 1'b1, 3'b001);
        check("seq_count", count, 16'd1);

        // Signed versus unsigned ordering.
        send_expect("slt_neg1", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100);
        send_expect("sltu_neg1", 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b010);
        send_expect("slt_min", 3'b010, 32'h8000_0000, 32'h0000_0001, 1'b1, 3'b100);
        send_expect("sltu_min", 3'b100, 32'h8000_0000, 32'h0000_0001, 1'b0, 3'b010);
        send_expect("sgt", 3'b110, 32'h0000_0005, 32'hFFFF_FFFB, 1'b1, 3'b010);
        send_expect("sle_eq", 3'b111, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b001);
        send_expect("sne_eq", 3'b001, 32'h0000_0007, 32'h0000_0007, 1'b0, 3'b001);

        // Backpressure: four beats offered back to back, sink stalled 5 cycles.
        bp_a[0] = 32'h11; bp_a[1] = 32'h22; bp_a[2] = 32'h33; bp_a[3] = 32'h44;
        out_ready = 1'b0;
        acc = 0;
        r0 = n_retired;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 3'b011; a = bp_a[acc]; b = 32'h22;
            cycle();
            if (g_in_fire) acc++;
        end
        check("bp_accepted", acc, 2);
        out_ready = 1'b1;
        tries = 0;
        while (acc < 4 && tries < 20) begin
            in_valid = 1'b1; op = 3'b011; a = bp_a[acc]; b = 32'h22;
            cycle();
            if (g_in_fire) acc++;
            tries++;
        end
        check("bp_all_in", acc, 4);
        idle(5);
        check("bp_retired", n_retired - r0, 4);

        // Flush with two beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; op = 3'b000; a = 32'h5; b = 32'h5;
            cycle();
        end
        c0 = m_count;
        r0 = n_retired;
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        check("flush_ovalid", out_valid, 1'b0);
        idle(4);
        check("flush_retired", n_retired - r0, 0);
        check("flush_count", count, c0[15:0]);

        // Async reset mid-stall, away from any clock edge.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op = 3'b100; a = 32'h1; b = 32'h2;
            cycle();
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ovalid", out_valid, 1'b0);
        check("arst_ready", in_ready, 1'b0);
        check("arst_result", result, 0);
        check("arst_flags", flags, 3'b000);
        check("arst_count", count, 16'd0);
        do_reset();

        // Randomized traffic with boundary-biased operands and rare flushes.
        for (int i = 0; i < 3000; i++) begin
            int mode;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            op        = 3'($urandom_range(0, 7));
            mode      = $urandom_range(0, 2);
            a = $urandom;
            b = $urandom;
            if (mode == 1) b = a;
            if (mode == 2) begin
                a = bnd[$urandom_range(0, 4)];
                b = bnd[$urandom_range(0, 4)];
            end
            cycle();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Count wrap: from a clean reset, 65535 true results then one more.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_valid = 1'b1; op = 3'b000; a = $urandom; b = a;
            cycle();
        end
        idle(3);
        check("wrap_ffff", count, 16'hFFFF);
        send_expect("wrap_last", 3'b000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 3'b001);
        check("wrap_zero", count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
